// File: rtl/booth32_if.sv
// Operand/result bundle for booth32: request strobe, operands, product and status.
// Latency: none, this is wires only.
// Backpressure: none; the requester watches busy/done and re-presents start when idle.
// Signals: start, a[31:0], b[31:0] (requester -> multiplier);
//          data_out[63:0], busy, done (multiplier -> requester).
interface booth32_if;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] data_out;
    logic        busy;
    logic        done;

    modport master (
        output start, a, b,
        input  data_out, busy, done
    );

    modport slave (
        input  start, a, b,
        output data_out, busy, done
    );
endinterface

// File: rtl/booth32.sv
// Sequential 32x32 signed multiplier using radix-4 Booth recoding, 64-bit registered product.
// Latency: start accepted at edge N -> done pulse with valid data_out in the cycle after edge N+17.
// Backpressure: start is ignored while busy or in DONE; no queueing, requester must retry.
// Ports: clk (rising-edge clock), clr (async active-low clear),
//        bus (booth32_if.slave: start/a/b in, data_out/busy/done out).
module booth32 (
    input  logic      clk,
    input  logic      clr,
    booth32_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;
    // Multiplier with an implicit b[-1]=0 appended; shifted right two bits per
    // iteration so the current Booth triplet is always b_q[2:0].
    logic [32:0] b_q, b_d;
    logic [63:0] acc_q, acc_d;
    logic [63:0] dout_q, dout_d;
    // 0..15 select the iteration; 16 is the final cycle that publishes the product.
    logic [4:0]  cnt_q, cnt_d;

    logic [33:0] a_ext;
    logic [33:0] pp;
    logic [63:0] term;

    // Partial product for the current triplet. 34 bits so that -2 * (-2^31)
    // = 2^32 is still representable as a positive signed value.
    always_comb begin
        a_ext = {{2{a_q[31]}}, a_q};
        case (b_q[2:0])
            3'b001, 3'b010: pp = a_ext;
            3'b011:         pp = a_ext << 1;
            3'b100:         pp = -(a_ext << 1);
            3'b101, 3'b110: pp = -a_ext;
            default:        pp = '0;
        endcase
        // Sign-extend to product width and weight by 4^i.
        term = {{30{pp[33]}}, pp} << {cnt_q[3:0], 1'b0};
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        bus.busy = 1'b0;
        bus.done = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = {bus.b, 1'b0};
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                bus.busy = 1'b1;
                if (cnt_q == 5'd16) begin
                    // All 16 digits accumulated; data_out changes only here so
                    // intermediate sums never become visible.
                    dout_d  = acc_q;
                    state_d = DONE;
                end else begin
                    acc_d = acc_q + term;
                    b_d   = b_q >> 2;
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.data_out = dout_q;

endmodule

// File: tb/tb_booth32.sv
// Self-checking bench for booth32: directed corner products, randomized operands
// with mid-operation disturbance, held-start throughput and asynchronous clear abort.
// Reference product is plain signed 64-bit arithmetic on the requested operands.
module tb_booth32;

    logic clk;
    logic clr;
    int   n_tests;
    int   n_fail;
    logic [63:0] prev_prod;

    booth32_if bus ();

    booth32 dut (
        .clk (clk),
        .clr (clr),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = $signed(x);
        sy = $signed(y);
        return 64'(sx * sy);
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input bit disturb);
        logic [63:0] exp;
        int lat;
        exp = ref_mul(op_a, op_b);
        bus.a     = op_a;
        bus.b     = op_b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) check("busy_calc", {63'd0, bus.busy}, 64'd1);
            if (k == 8) check("data_out_hold", bus.data_out, prev_prod);
            if (disturb && k == 5) begin
                bus.start = 1'b1;
                bus.a     = $urandom;
                bus.b     = $urandom;
            end
            if (disturb && k == 7) bus.start = 1'b0;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
        check("latency", 64'(lat), 64'd17);
        check("product", bus.data_out, exp);
        check("busy_in_done", {63'd0, bus.busy}, 64'd0);
        prev_prod = exp;
        @(posedge clk);
        @(negedge clk);
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int gap;
        bit seen;

        n_tests   = 0;
        n_fail    = 0;
        prev_prod = '0;
        clr       = 1'b0;
        bus.start = 1'b0;
        bus.a     = 32'd0;
        bus.b     = 32'd0;

        #2;
        check("rst_data_out", bus.data_out, 64'd0);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        // Directed corner cases.
        run_op(32'd65, 32'd200, 1'b0);
        run_op(32'd1, 32'd1, 1'b0);
        run_op(32'd0, $urandom, 1'b0);
        run_op(32'hFFFF_FFFB, 32'd8, 1'b0);
        run_op(32'hFFFF_FFF6, 32'hFFFF_FFFA, 1'b0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        run_op(32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1);

        // Randomized operands, every other one disturbed mid-operation.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom;
            run_op(ra, rb, i[0]);
        end

        // Start held high: consecutive done pulses are 19 edges apart.
        ra = $urandom;
        rb = $urandom;
        bus.a     = ra;
        bus.b     = rb;
        bus.start = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("held_first_done", {63'd0, seen}, 64'd1);
        check("held_first_prod", bus.data_out, ref_mul(ra, rb));
        gap = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.done) begin
                gap = k;
                break;
            end
        end
        bus.start = 1'b0;
        check("held_period", 64'(gap), 64'd19);
        check("held_second_prod", bus.data_out, ref_mul(ra, rb));
        prev_prod = ref_mul(ra, rb);
        @(posedge clk);
        @(negedge clk);

        // Clear mid-operation aborts; next start right after release completes normally.
        bus.a     = 32'd65;
        bus.b     = 32'd200;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        check("clr_busy", {63'd0, bus.busy}, 64'd0);
        check("clr_data_out", bus.data_out, 64'd0);
        check("clr_done", {63'd0, bus.done}, 64'd0);
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
        check("clr_no_done", {63'd0, seen}, 64'd0);
        clr = 1'b1;
        prev_prod = '0;
        run_op(32'hFFFF_FFFB, 32'd8, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
